npc_mc_ctrl: RTL and testbench
==============================

# npc_mc_ctrl

Multi-cycle control sequencer for the NPC RV64IM core. It replaces the single-cycle combinational control unit. Each instruction is fetched over a req/ack handshake and latched into an internal instruction register, then decoded into a registered control bundle. Execution is stepped through EXEC, optional multi-cycle mul/div, optional memory access, and write-back. Illegal instructions, ebreak and bus timeouts drive a sticky halt output.

## Interface
Parameters:
- XLEN, 64: datapath width. When 32, every W-form opcode (0011011, 0111011) and ld/sd decode as illegal.
- RV_M, 1: when 0, every funct7=0000001 op decodes as illegal.
- MEM_TIMEOUT, 256: maximum cycles a request may wait for its ack. 0 disables the timeout.

Ports. Clock is `clk`. Reset is `rst_n`, asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ifu_req  out  1  fetch request
- ifu_ack  in  1  fetch done; ifu_instr valid this cycle
- ifu_instr  in  32  fetched instruction
- br_taken  in  1  branch condition from the ALU, sampled in WB
- alu_ctrl  out  4  ALU codes: Adder 0, Shift 1, Compare 2, Div 3, Logic 4, Mul 5, Auipc 6, Lui 7, 15 unused
- alu_inner  out  4  ALU sub-op 0..5, 15 unused
- sext_ctrl  out  3  immediate type: I 1, U 2, S 3, J 4, B 5
- src1_pc, src2_imm, wb_sel_mem, wb_sel_npc  out  1 each  datapath muxes
- npc_sel  out  2  0 = pc+4, 1 = branch/jal, 2 = jalr
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_done  in  1  mul/div result valid
- lsu_req  out  1  memory request
- lsu_we  out  1  store
- lsu_ctrl  out  4  access size/sign, same code as MEM_Ctrl
- lsu_ack  in  1  memory done
- rf_we, pc_we  out  1  commit strobes
- halt  out  1  sticky halt
- halt_cause  out  2  0 none, 1 ebreak, 2 illegal, 3 timeout
- instret  out  64  retired-instruction count

## Operation
States: BOOT, FETCH, DECODE, EXEC, MDWAIT, MEM, WB, HALT. Reset enters BOOT, and all outputs are 0.

- **BOOT:** lasts 1 cycle, then goes to FETCH.
- **FETCH:** ifu_req is held at 1 until ifu_ack. On ack, latch ifu_instr into the instruction register and go to DECODE.
- **DECODE:** register the full control bundle from the instruction register.
  - ebreak (0x00100073) goes to HALT with cause 1.
  - Any opcode/funct combination outside the supported set goes to HALT with cause 2.
  - Everything else goes to EXEC.
- **EXEC:**
  - Mul/div/rem: md_start=1 for this cycle only, then go to MDWAIT.
  - Load/store: go to MEM.
  - Otherwise: go to WB.
- **MDWAIT:** wait for md_done, then go to WB. An md_done arriving in EXEC is ignored.
- **MEM:** lsu_req is held at 1, with lsu_we/lsu_ctrl held stable, until lsu_ack.
  - Load: go to WB.
  - Store: pc_we=1 in the ack cycle, instret increments, then go to FETCH.
- **WB:** pc_we=1.
  - rf_we=1 unless the instruction is a branch.
  - For branches, npc_sel = br_taken ? 1 : 0. jal gives 1, jalr gives 2.
  - instret increments.
  - Go to FETCH.
- **HALT:** terminal. halt=1, halt_cause is held, and all request and commit strobes are 0. Only reset leaves HALT.

Timeout:
- A counter clears on entry to FETCH or MEM and increments each cycle that the request is unacknowledged.
- An ack in the same cycle the count reaches MEM_TIMEOUT is accepted.
- Otherwise, when the count reaches MEM_TIMEOUT, go to HALT with cause 3.

Invariants:
- rf_we and pc_we each pulse at most once per instruction.
- The registered control bundle is stable from DECODE+1 until the next DECODE.
- instret wraps modulo 2^64.
- Reset asserted in any state aborts any outstanding request immediately. Acks arriving after that are ignored.

## Timing
Cycle counts below assume zero-wait acks (ack in the first request cycle).
- ALU/branch/jump instruction: FETCH, DECODE, EXEC, WB = 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Mul/div: 4 + md latency. md latency is counted from the md_start cycle, exclusive.
- Each ack wait cycle adds 1.
- Control outputs change only on clk edges, except asynchronously to 0 on reset.
- ifu_req first rises in the cycle after BOOT.

## Structure
- Shared package `npc_ctrl_pkg` holds:
  - the state enum;
  - the ALU, inner, sext, npc_sel and halt_cause code constants;
  - the opcode/funct3/funct7 constants;
  - the packed control-bundle struct.
- Sub-module `npc_idecode`: purely combinational, instruction in, control bundle plus illegal/ebreak flags out. It is instantiated once.
- The FSM, timeout counter and instret stay in the top module.

## Test plan
- Reset release, zero-wait fetch of addi (0x00500093): ifu_req at cycle 1; rf_we=1, pc_we=1, npc_sel=0 at cycle 4; instret=1.
- ld with lsu_ack delayed 3 cycles: lsu_req held 4 cycles; wb_sel_mem=1; rf_we in the cycle after ack; total 8 cycles.
- beq with br_taken=1, then bne with br_taken=0: npc_sel=1 then 0; rf_we=0 for both; instret=2.
- mul with md_done 5 cycles after md_start: exactly one md_start; WB the cycle after md_done; a spurious md_done in EXEC is ignored.
- 0xFFFFFFFF, then ebreak after reset: halt=1, cause 2; after reset, cause 1; no further ifu_req in either case.
- MEM_TIMEOUT=4, fetch never acked: halt cause 3 after 4 req cycles. An ack on the 4th cycle is accepted. rst_n pulsed mid-MEM drops lsu_req to 0 immediately.

Source files
------------

// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: states, datapath control codes, RV64IM opcode fields and the
// registered control bundle shared by the NPC multi-cycle controller.
package npc_ctrl_pkg;
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MDWAIT, S_MEM, S_WB, S_HALT} state_e;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SHIFT = 4'd1, ALU_CMP = 4'd2, ALU_DIV = 4'd3,
                         ALU_LOGIC = 4'd4, ALU_MUL = 4'd5, ALU_AUIPC = 4'd6, ALU_LUI = 4'd7,
                         ALU_NONE = 4'd15;
  localparam logic [3:0] IN_ADD = 4'd0, IN_SUB = 4'd1, IN_SLL = 4'd0, IN_SRL = 4'd1, IN_SRA = 4'd2,
                         IN_LT = 4'd2, IN_LTU = 4'd4, IN_AND = 4'd0, IN_OR = 4'd1, IN_XOR = 4'd2,
                         IN_NONE = 4'd15;
  localparam logic [2:0] SX_NONE = 3'd0, SX_I = 3'd1, SX_U = 3'd2, SX_S = 3'd3, SX_J = 3'd4, SX_B = 3'd5;
  localparam logic [1:0] NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_JALR = 2'd2;
  localparam logic [1:0] HC_NONE = 2'd0, HC_EBREAK = 2'd1, HC_ILLEGAL = 2'd2, HC_TIMEOUT = 2'd3;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011,
                         OP_REG = 7'b0110011, OP_REG32 = 7'b0111011;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [3:0] alu_inner;
    logic [2:0] sext;
    logic       src1_pc;
    logic       src2_imm;
    logic       wb_sel_mem;
    logic       wb_sel_npc;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_md;
    logic       is_load;
    logic       is_store;
    logic [3:0] lsu_ctrl;
  } ctrl_t;
  // {alu_ctrl, alu_inner} for the shared OP / OP-IMM funct3 map; alt selects sub/sra
  function automatic logic [7:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f3 = {ALU_ADD, alt ? IN_SUB : IN_ADD};
      3'd1:    alu_f3 = {ALU_SHIFT, IN_SLL};
      3'd2:    alu_f3 = {ALU_CMP, IN_LT};
      3'd3:    alu_f3 = {ALU_CMP, IN_LTU};
      3'd4:    alu_f3 = {ALU_LOGIC, IN_XOR};
      3'd5:    alu_f3 = {ALU_SHIFT, alt ? IN_SRA : IN_SRL};
      3'd6:    alu_f3 = {ALU_LOGIC, IN_OR};
      default: alu_f3 = {ALU_LOGIC, IN_AND};
    endcase
  endfunction
endpackage

// File: rtl/npc_idecode.sv
// npc_idecode: combinational RV64IM decoder producing the control bundle and
// illegal/ebreak flags for one instruction word.
module npc_idecode
  import npc_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit RV_M = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        ebreak
);
  localparam bit RV64 = (XLEN == 64);
  logic [6:0] op, f7, sh_fn;
  logic [2:0] f3;
  logic       legal;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  // RV64 shift-immediates use a 6-bit shamt, so only instr[31:26] select the op
  assign sh_fn = RV64 ? {instr[31:26], 1'b0} : f7;
  assign ebreak = (instr == EBREAK);
  assign illegal = !legal && !ebreak;
  always_comb begin
    ctrl = '0;
    ctrl.alu_ctrl = ALU_NONE;
    ctrl.alu_inner = IN_NONE;
    legal = 1'b0;
    case (op)
      OP_LUI: begin
        legal = 1'b1;
        ctrl.alu_ctrl = ALU_LUI;
        ctrl.sext = SX_U;
        ctrl.src2_imm = 1'b1;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        ctrl.alu_ctrl = ALU_AUIPC;
        ctrl.sext = SX_U;
        ctrl.src1_pc = 1'b1;
        ctrl.src2_imm = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1;
        {ctrl.alu_ctrl, ctrl.alu_inner} = {ALU_ADD, IN_ADD};
        ctrl.sext = SX_J;
        ctrl.src1_pc = 1'b1;
        ctrl.src2_imm = 1'b1;
        ctrl.wb_sel_npc = 1'b1;
        ctrl.is_jal = 1'b1;
      end
      OP_JALR: begin
        legal = (f3 == 3'd0);
        {ctrl.alu_ctrl, ctrl.alu_inner} = {ALU_ADD, IN_ADD};
        ctrl.sext = SX_I;
        ctrl.src2_imm = 1'b1;
        ctrl.wb_sel_npc = 1'b1;
        ctrl.is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        legal = (f3[2:1] != 2'b01);
        ctrl.alu_ctrl = ALU_CMP;
        ctrl.alu_inner = f3[2] ? {1'b0, f3} - 4'd2 : {1'b0, f3};
        ctrl.sext = SX_B;
        ctrl.is_branch = 1'b1;
      end
      OP_LOAD: begin
        legal = (f3 != 3'd7) && (RV64 || (f3 != 3'd3 && f3 != 3'd6));
        {ctrl.alu_ctrl, ctrl.alu_inner} = {ALU_ADD, IN_ADD};
        ctrl.sext = SX_I;
        ctrl.src2_imm = 1'b1;
        ctrl.wb_sel_mem = 1'b1;
        ctrl.is_load = 1'b1;
        ctrl.lsu_ctrl = {1'b0, f3};
      end
      OP_STORE: begin
        legal = !f3[2] && (RV64 || f3 != 3'd3);
        {ctrl.alu_ctrl, ctrl.alu_inner} = {ALU_ADD, IN_ADD};
        ctrl.sext = SX_S;
        ctrl.src2_imm = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.lsu_ctrl = {1'b0, f3};
      end
      OP_IMM: begin
        legal = (f3 == 3'd1) ? (sh_fn == F7_BASE) :
                (f3 == 3'd5) ? (sh_fn == F7_BASE || sh_fn == F7_ALT) : 1'b1;
        {ctrl.alu_ctrl, ctrl.alu_inner} = alu_f3(f3, f3 == 3'd5 && instr[30]);
        ctrl.sext = SX_I;
        ctrl.src2_imm = 1'b1;
      end
      OP_IMM32: begin
        legal = RV64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == F7_BASE) ||
                         (f3 == 3'd5 && (f7 == F7_BASE || f7 == F7_ALT)));
        {ctrl.alu_ctrl, ctrl.alu_inner} = alu_f3(f3, f3 == 3'd5 && instr[30]);
        ctrl.sext = SX_I;
        ctrl.src2_imm = 1'b1;
      end
      OP_REG, OP_REG32: begin
        if (f7 == F7_MULDIV) begin
          legal = RV_M && (op == OP_REG || (RV64 && (f3 == 3'd0 || f3[2])));
          ctrl.alu_ctrl = f3[2] ? ALU_DIV : ALU_MUL;
          ctrl.alu_inner = {2'b00, f3[1:0]};
          ctrl.is_md = 1'b1;
        end else begin
          legal = (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5))) &&
                  (op == OP_REG || (RV64 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)));
          {ctrl.alu_ctrl, ctrl.alu_inner} = alu_f3(f3, instr[30]);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/npc_mc_ctrl.sv
// npc_mc_ctrl: multi-cycle control sequencer for the NPC RV64IM core: fetch
// handshake, registered decode, mul/div and memory waits, commit and sticky halt.
module npc_mc_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit RV_M        = 1'b1,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  input  logic        ifu_ack,
  input  logic [31:0] ifu_instr,
  input  logic        br_taken,
  output logic [3:0]  alu_ctrl,
  output logic [3:0]  alu_inner,
  output logic [2:0]  sext_ctrl,
  output logic        src1_pc,
  output logic        src2_imm,
  output logic        wb_sel_mem,
  output logic        wb_sel_npc,
  output logic [1:0]  npc_sel,
  output logic        md_start,
  input  logic        md_done,
  output logic        lsu_req,
  output logic        lsu_we,
  output logic [3:0]  lsu_ctrl,
  input  logic        lsu_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [63:0] instret
);
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  ctrl_t         ctrl_q, ctrl_d, dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    hc_q, hc_d;
  logic [63:0]   instret_q, instret_d;
  logic          illegal, ebreak, tmo;
  npc_idecode #(.XLEN(XLEN), .RV_M(RV_M)) u_idecode (
    .instr   (ir_q),
    .ctrl    (dec),
    .illegal (illegal),
    .ebreak  (ebreak)
  );
  // the count reaches the limit this cycle; an ack in the same cycle still wins
  assign tmo = (MEM_TIMEOUT != 0) && (32'(cnt_q) == 32'(MEM_TIMEOUT - 1));
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign alu_inner  = ctrl_q.alu_inner;
  assign sext_ctrl  = ctrl_q.sext;
  assign src1_pc    = ctrl_q.src1_pc;
  assign src2_imm   = ctrl_q.src2_imm;
  assign wb_sel_mem = ctrl_q.wb_sel_mem;
  assign wb_sel_npc = ctrl_q.wb_sel_npc;
  assign lsu_ctrl   = ctrl_q.lsu_ctrl;
  assign halt       = (state_q == S_HALT);
  assign halt_cause = hc_q;
  assign instret    = instret_q;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    ctrl_d = ctrl_q;
    hc_d = hc_q;
    instret_d = instret_q;
    ifu_req = 1'b0;
    md_start = 1'b0;
    lsu_req = 1'b0;
    lsu_we = 1'b0;
    rf_we = 1'b0;
    pc_we = 1'b0;
    npc_sel = NPC_SEQ;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        ifu_req = 1'b1;
        ir_d = ifu_ack ? ifu_instr : ir_q;
        state_d = ifu_ack ? S_DECODE : tmo ? S_HALT : S_FETCH;
        hc_d = (!ifu_ack && tmo) ? HC_TIMEOUT : hc_q;
      end
      S_DECODE: begin
        ctrl_d = dec;
        state_d = (ebreak || illegal) ? S_HALT : S_EXEC;
        hc_d = ebreak ? HC_EBREAK : illegal ? HC_ILLEGAL : hc_q;
      end
      S_EXEC: begin
        md_start = ctrl_q.is_md;
        state_d = ctrl_q.is_md ? S_MDWAIT : (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      end
      S_MDWAIT: state_d = md_done ? S_WB : S_MDWAIT;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_we = ctrl_q.is_store;
        pc_we = lsu_ack && ctrl_q.is_store;
        instret_d = instret_q + {63'd0, pc_we};
        state_d = lsu_ack ? (ctrl_q.is_store ? S_FETCH : S_WB) : tmo ? S_HALT : S_MEM;
        hc_d = (!lsu_ack && tmo) ? HC_TIMEOUT : hc_q;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = !ctrl_q.is_branch;
        npc_sel = ctrl_q.is_branch ? {1'b0, br_taken} : ctrl_q.is_jalr ? NPC_JALR :
                  ctrl_q.is_jal ? NPC_BR : NPC_SEQ;
        instret_d = instret_q + 64'd1;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      ir_q <= '0;
      ctrl_q <= '0;
      cnt_q <= '0;
      hc_q <= HC_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
      hc_q <= hc_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_npc_mc_ctrl.sv
// tb_npc_mc_ctrl: directed cycle-by-cycle vectors for npc_mc_ctrl with
// hand-computed expectations; the DUT uses a fetch/memory timeout of 4.
module tb_npc_mc_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ifu_req, ifu_ack, br_taken, src1_pc, src2_imm, wb_sel_mem, wb_sel_npc;
  logic        md_start, md_done, lsu_req, lsu_we, lsu_ack, rf_we, pc_we, halt;
  logic [31:0] ifu_instr;
  logic [3:0]  alu_ctrl, alu_inner, lsu_ctrl;
  logic [2:0]  sext_ctrl;
  logic [1:0]  npc_sel, halt_cause;
  logic [63:0] instret;
  int          n_vec = 0, n_err = 0, cnt = 0;

  always #5 clk = ~clk;

  npc_mc_ctrl #(.XLEN(64), .RV_M(1'b1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ifu_instr(ifu_instr),
    .br_taken(br_taken), .alu_ctrl(alu_ctrl), .alu_inner(alu_inner), .sext_ctrl(sext_ctrl),
    .src1_pc(src1_pc), .src2_imm(src2_imm), .wb_sel_mem(wb_sel_mem), .wb_sel_npc(wb_sel_npc),
    .npc_sel(npc_sel), .md_start(md_start), .md_done(md_done), .lsu_req(lsu_req),
    .lsu_we(lsu_we), .lsu_ctrl(lsu_ctrl), .lsu_ack(lsu_ack), .rf_we(rf_we), .pc_we(pc_we),
    .halt(halt), .halt_cause(halt_cause), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // leaves the bench 3 time units into cycle 0 (BOOT) with reset released
  task automatic do_reset;
    rst_n = 1'b0;
    {ifu_ack, lsu_ack, md_done, br_taken} = 4'b0000;
    ifu_instr = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic step(input logic ia = 1'b0, input logic [31:0] ins = 32'h0,
                      input logic la = 1'b0, input logic md = 1'b0, input logic br = 1'b0);
    @(posedge clk);
    #2;
    ifu_ack = ia;
    ifu_instr = ins;
    lsu_ack = la;
    md_done = md;
    br_taken = br;
    #1;
  endtask

  initial begin
    // addi x1, x0, 5 with zero-wait fetch
    do_reset();
    chk("rst_strobes", {ifu_req, lsu_req, lsu_we, md_start, rf_we, pc_we, halt}, 7'd0);
    chk("rst_bundle", {alu_ctrl, alu_inner, sext_ctrl, lsu_ctrl, npc_sel, halt_cause}, 19'd0);
    chk("rst_instret", instret, 64'd0);
    step(1'b1, 32'h0050_0093);
    chk("addi_c1_req", ifu_req, 1'b1);
    step();
    chk("addi_c2_req_drop", ifu_req, 1'b0);
    step();
    chk("addi_c3_bundle", {alu_ctrl, alu_inner, sext_ctrl, src1_pc, src2_imm},
        {4'd0, 4'd0, 3'd1, 1'b0, 1'b1});
    chk("addi_c3_no_commit", {rf_we, pc_we}, 2'b00);
    step();
    chk("addi_c4_wb", {rf_we, pc_we, npc_sel}, {1'b1, 1'b1, 2'd0});
    step();
    chk("addi_c5_strobes", {rf_we, pc_we, ifu_req}, 3'b001);
    chk("addi_instret", instret, 64'd1);

    // ld x1, 0(x2) with lsu_ack on the 4th request cycle (the timeout edge)
    do_reset();
    step(1'b1, 32'h0001_3083);
    step();
    step();
    chk("ld_c3_no_req", lsu_req, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, i == 3);
      cnt += int'(lsu_req);
      chk("ld_mem_ctrl", {lsu_we, lsu_ctrl, pc_we, rf_we}, {1'b0, 4'd3, 1'b0, 1'b0});
    end
    chk("ld_req_cycles", cnt, 64'd4);
    step();
    chk("ld_c8_wb", {rf_we, pc_we, wb_sel_mem, lsu_req, halt}, 5'b11100);
    step();
    chk("ld_instret", instret, 64'd1);

    // beq taken, bne not taken, then jalr
    do_reset();
    step(1'b1, 32'h0000_0463);
    step();
    step();
    chk("beq_bundle", {alu_ctrl, alu_inner, sext_ctrl}, {4'd2, 4'd0, 3'd5});
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("beq_wb", {rf_we, pc_we, npc_sel}, {1'b0, 1'b1, 2'd1});
    step(1'b1, 32'h0000_9463);
    chk("br_instret1", instret, 64'd1);
    step();
    step();
    chk("bne_inner", alu_inner, 4'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bne_wb", {rf_we, pc_we, npc_sel}, {1'b0, 1'b1, 2'd0});
    step(1'b1, 32'h0001_00E7);
    chk("br_instret2", instret, 64'd2);
    step();
    step();
    chk("jalr_bundle", {alu_ctrl, sext_ctrl, src2_imm, wb_sel_npc}, {4'd0, 3'd1, 1'b1, 1'b1});
    step();
    chk("jalr_wb", {rf_we, pc_we, npc_sel}, {1'b1, 1'b1, 2'd2});

    // sd x3, 0(x2): pc_we in the ack cycle, no rf_we
    do_reset();
    step(1'b1, 32'h0031_3023);
    step();
    step();
    step(1'b0, 32'h0, 1'b1);
    chk("sd_mem_ack", {lsu_req, lsu_we, lsu_ctrl, pc_we, rf_we}, {1'b1, 1'b1, 4'd3, 1'b1, 1'b0});
    step();
    chk("sd_c5_fetch", {ifu_req, pc_we, lsu_req}, 3'b100);
    chk("sd_instret", instret, 64'd1);

    // mul x1, x2, x3: spurious md_done in EXEC, real one 5 cycles after md_start
    do_reset();
    step(1'b1, 32'h0231_00B3);
    step();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mul_c3_start", md_start, 1'b1);
    cnt = int'(md_start);
    for (int i = 4; i <= 8; i++) begin
      step(1'b0, 32'h0, 1'b0, i == 8);
      cnt += int'(md_start);
      chk("mul_wait_no_commit", {rf_we, pc_we}, 2'b00);
    end
    chk("mul_alu", alu_ctrl, 4'd5);
    step();
    cnt += int'(md_start);
    chk("mul_c9_wb", {rf_we, pc_we}, 2'b11);
    chk("mul_start_pulses", cnt, 64'd1);
    step();
    chk("mul_instret", instret, 64'd1);

    // all-ones word is illegal; halt holds with no further fetches
    do_reset();
    step(1'b1, 32'hFFFF_FFFF);
    step();
    step();
    chk("ill_halt", {halt, halt_cause}, {1'b1, 2'd2});
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0050_0093, 1'b1, 1'b1);
      cnt += int'(ifu_req);
      chk("ill_hold", {halt, halt_cause, rf_we, pc_we, lsu_req, md_start}, {1'b1, 2'd2, 4'b0000});
    end
    chk("ill_no_fetch", cnt, 64'd0);

    // sll with the sub/sra funct7 is outside the supported set
    do_reset();
    step(1'b1, 32'h4020_90B3);
    step();
    step();
    chk("ill_f7_halt", {halt, halt_cause}, {1'b1, 2'd2});

    // ebreak after reset
    do_reset();
    chk("ebr_rst_clears", {halt, halt_cause}, 3'd0);
    step(1'b1, 32'h0010_0073);
    step();
    step();
    chk("ebr_halt", {halt, halt_cause}, {1'b1, 2'd1});
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0050_0093);
      cnt += int'(ifu_req);
    end
    chk("ebr_no_fetch", cnt, 64'd0);

    // fetch never acked: 4 request cycles then timeout halt
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(ifu_req);
    end
    chk("tmo_req_cycles", cnt, 64'd4);
    step();
    chk("tmo_halt", {halt, halt_cause, ifu_req}, {1'b1, 2'd3, 1'b0});

    // ack on the 4th request cycle is accepted
    do_reset();
    step();
    step();
    step();
    step(1'b1, 32'h0050_0093);
    chk("tmo_edge_req", ifu_req, 1'b1);
    step();
    chk("tmo_edge_accept", {halt, ifu_req}, 2'b00);
    step();
    step();
    chk("tmo_edge_wb", {rf_we, pc_we}, 2'b11);

    // reset mid-MEM drops the request at once; a late ack is ignored
    do_reset();
    step(1'b1, 32'h0001_3083);
    step();
    step();
    step();
    chk("rst_mem_req", lsu_req, 1'b1);
    #1 rst_n = 1'b0;
    lsu_ack = 1'b1;
    #0.5;
    chk("rst_async_drop", {lsu_req, lsu_we, ifu_req, pc_we}, 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_boot_ack_ignored", {lsu_req, pc_we, rf_we, ifu_req}, 4'b0000);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_refetch", {ifu_req, lsu_req, pc_we, rf_we}, 4'b1000);
    chk("rst_instret", instret, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
